// File: rtl/wkt_btn_pkg.sv
// Shared types and helpers for the push-button debouncer slice.
package wkt_btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } btn_state_t;

  // Width of an event index for n channels; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wkt_buttons_if.sv
// Event handshake between the button block (master) and its consumer (slave).
interface wkt_buttons_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_long;
  logic            evt_ack;

  modport master (output evt_valid, output evt_id, output evt_long, input evt_ack);
  modport slave  (input evt_valid, input evt_id, input evt_long, output evt_ack);
endinterface

// File: rtl/wkt_btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and counter, optional
// long-press counter (compiled in with WKT_BTN_LONGPRESS_EN).
module wkt_btn_channel
  import wkt_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef WKT_BTN_LONGPRESS_EN
  ,
  parameter int unsigned LONG_CYCLES = 50000000
`endif
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press_evt
`ifdef WKT_BTN_LONGPRESS_EN
  ,
  output logic long_evt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  btn_state_t       state;

  // Synchronize the raw level and debounce it in both directions.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync      <= '0;
      cnt       <= '0;
      state     <= IDLE;
      level     <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      sync      <= {sync[0], btn_raw};
      press_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (sync[1]) begin
            state <= CHK_PRESS;
            cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!sync[1]) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            level     <= 1'b1;
            press_evt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync[1]) begin
            state <= CHK_RELEASE;
            cnt   <= '0;
          end
        end
        CHK_RELEASE: begin
          if (sync[1]) begin
            state <= PRESSED;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WKT_BTN_LONGPRESS_EN
  localparam int unsigned LCNT_W = $clog2(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYCLES - 1);

  logic [LCNT_W-1:0] lcnt;
  logic              long_done;

  // Time the hold in PRESSED; fire once per press, re-armed only back in IDLE
  // so a release bounce that returns to PRESSED cannot fire a second time.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lcnt      <= '0;
      long_done <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      long_evt <= 1'b0;
      if (state == PRESSED) begin
        if (!long_done) begin
          if (lcnt == LCNT_MAX) begin
            long_evt  <= 1'b1;
            long_done <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
      end else begin
        lcnt <= '0;
        if (state == IDLE) begin
          long_done <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/wkt_buttons.sv
// NBTN debounced push buttons with a press-event queue of one flag per
// channel and event type, lowest-index-first arbitration and a valid/ack
// handshake. Long-press events exist only with WKT_BTN_LONGPRESS_EN defined.
module wkt_buttons
  import wkt_btn_pkg::*;
#(
  parameter int unsigned NBTN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NBTN-1:0] i_btn,
  output logic [NBTN-1:0] o_btn,
  output logic            o_overrun,
  wkt_buttons_if.master   evt
);

  localparam int unsigned ID_W = id_width(NBTN);

  // Reject out-of-range configurations at elaboration.
  if (NBTN < 1 || NBTN > 8) begin : g_bad_nbtn
    $error("wkt_buttons: NBTN must be 1..8");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFFFFFF) begin : g_bad_deb
    $error("wkt_buttons: DEBOUNCE_CYCLES must be 2..2^24-1");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("wkt_buttons: LONG_CYCLES must be at least 2");
  end

  logic [NBTN-1:0] level;
  logic [NBTN-1:0] press_set, press_pend, press_clr, press_avail;
  logic            sel_valid;
  logic [ID_W-1:0] sel_id;
  logic            lost_c;
`ifdef WKT_BTN_LONGPRESS_EN
  logic [NBTN-1:0] long_set, long_pend, long_clr, long_avail;
  logic            sel_long;
`endif

  // One debounce channel per button.
  for (genvar g = 0; g < int'(NBTN); g++) begin : g_chan
    wkt_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef WKT_BTN_LONGPRESS_EN
      ,
      .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .btn_raw   (i_btn[g]),
      .level     (level[g]),
      .press_evt (press_set[g])
`ifdef WKT_BTN_LONGPRESS_EN
      ,
      .long_evt  (long_set[g])
`endif
    );
  end

  // Clear the presented flag on ack, then pick the lowest pending channel,
  // press before long; the pick is what gets presented next cycle.
  always_comb begin
    press_clr = '0;
    sel_valid = 1'b0;
    sel_id    = '0;
`ifdef WKT_BTN_LONGPRESS_EN
    long_clr  = '0;
    sel_long  = 1'b0;
`endif
    for (int i = 0; i < int'(NBTN); i++) begin
      if (evt.evt_valid && evt.evt_ack && evt.evt_id == ID_W'(i)) begin
`ifdef WKT_BTN_LONGPRESS_EN
        if (evt.evt_long) long_clr[i] = 1'b1;
        else              press_clr[i] = 1'b1;
`else
        press_clr[i] = 1'b1;
`endif
      end
    end
    press_avail = press_pend & ~press_clr;
`ifdef WKT_BTN_LONGPRESS_EN
    long_avail  = long_pend & ~long_clr;
`endif
    for (int i = int'(NBTN) - 1; i >= 0; i--) begin
`ifdef WKT_BTN_LONGPRESS_EN
      if (long_avail[i]) begin
        sel_valid = 1'b1;
        sel_id    = ID_W'(i);
        sel_long  = 1'b1;
      end
`endif
      if (press_avail[i]) begin
        sel_valid = 1'b1;
        sel_id    = ID_W'(i);
`ifdef WKT_BTN_LONGPRESS_EN
        sel_long  = 1'b0;
`endif
      end
    end
    // A new event landing on a still-pending same-type flag is lost.
    lost_c = |(press_set & press_avail);
`ifdef WKT_BTN_LONGPRESS_EN
    lost_c = lost_c | (|(long_set & long_avail));
`endif
  end

`ifndef WKT_BTN_LONGPRESS_EN
  assign evt.evt_long = 1'b0;
`endif

  // Flag registers, sticky overrun and the presented-event registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_btn         <= '0;
      o_overrun     <= 1'b0;
      press_pend    <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
`ifdef WKT_BTN_LONGPRESS_EN
      long_pend     <= '0;
      evt.evt_long  <= 1'b0;
`endif
    end else begin
      o_btn      <= level;
      o_overrun  <= o_overrun | lost_c;
      press_pend <= press_avail | press_set;
`ifdef WKT_BTN_LONGPRESS_EN
      long_pend  <= long_avail | long_set;
`endif
      if (!evt.evt_valid || evt.evt_ack) begin
        evt.evt_valid <= sel_valid;
        evt.evt_id    <= sel_id;
`ifdef WKT_BTN_LONGPRESS_EN
        evt.evt_long  <= sel_long;
`endif
      end
    end
  end

endmodule

// File: doc/wkt_buttons.md
WKT_BUTTONS -- requirements
Module: wkt_buttons

Interface
REQ-001 Parameter NBTN, default 4: number of push-button inputs, 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: number of consecutive stable synchronized samples required to accept a level change, 2..2^24-1.
REQ-003 Parameter LONG_CYCLES, default 50000000: hold time in clocks that qualifies a long press, used only when the long-press feature is compiled in.
REQ-004 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 i_reset_n  input  1  reset, synchronous and active-low.
REQ-006 i_btn  input  NBTN  raw asynchronous button levels, 1 = pressed.
REQ-007 o_btn  output  NBTN  debounced button levels.
REQ-008 o_evt_valid  output  1  press event pending.
REQ-009 o_evt_id  output  clog2(NBTN) (minimum 1)  index of the presented event.
REQ-010 o_evt_long  output  1  presented event is a long press.
REQ-011 i_evt_ack  input  1  consumer accepts the presented event.
REQ-012 o_overrun  output  1  sticky flag: an event was lost.

Function
REQ-013 Each i_btn bit SHALL pass a 2-flop synchronizer before any other logic uses it.
REQ-014 Each channel SHALL run a 4-state FSM with states IDLE, CHK_PRESS, PRESSED and CHK_RELEASE.
REQ-015 IDLE: a synchronized 1 moves the channel to CHK_PRESS with the debounce counter cleared.
REQ-016 CHK_PRESS: a synchronized 0 returns the channel to IDLE; if the counter reaches DEBOUNCE_CYCLES-1, the channel moves to PRESSED, sets its o_btn bit to 1 and sets its press-pending flag.
REQ-017 PRESSED and CHK_RELEASE SHALL be symmetric to IDLE and CHK_PRESS: the release sets the o_btn bit to 0 and generates no event.
REQ-018 For a clean press, the o_btn bit SHALL rise exactly DEBOUNCE_CYCLES+3 clocks after the first edge that samples i_btn high; a glitch shorter than DEBOUNCE_CYCLES samples SHALL cause no o_btn change and no event.
REQ-019 o_evt_valid SHALL be registered and SHALL be high in the cycle after any pending flag becomes set.
REQ-020 o_evt_id SHALL select the lowest-index pending channel, and press events SHALL have priority over long events on the same channel.
REQ-021 While o_evt_valid is high, o_evt_id and o_evt_long SHALL hold stable until a cycle in which i_evt_ack is sampled high.
REQ-022 The ack SHALL clear only the presented flag, and the next pending event SHALL be presented in the following cycle.
REQ-023 i_evt_ack while o_evt_valid is low SHALL be ignored.
REQ-024 If a flag is set and cleared in the same cycle, the set SHALL win and the event stays pending.
REQ-025 A new event on a channel whose same-type flag is already pending SHALL set o_overrun and SHALL NOT queue a second event.
REQ-026 o_overrun SHALL be cleared only by reset.

Reset
REQ-027 When i_reset_n is low at a clock edge, the block SHALL set all FSMs to IDLE and clear all counters, synchronizers and flags.
REQ-028 When i_reset_n is low at a clock edge, the block SHALL drive o_btn=0, o_evt_valid=0, o_evt_id=0, o_evt_long=0 and o_overrun=0.
REQ-029 Reset asserted mid-debounce or mid-handshake SHALL discard the pending state, and a button already held at reset release SHALL be re-debounced from IDLE.

Configuration
REQ-030 With macro WKT_BTN_LONGPRESS_EN defined, each channel SHALL count clocks in PRESSED and, at LONG_CYCLES, set its long-pending flag once per press; the counter SHALL clear on leaving PRESSED.
REQ-031 Without WKT_BTN_LONGPRESS_EN, no long counters or long flags SHALL exist and o_evt_long SHALL be tied to 0.

Structure
REQ-032 Package wkt_btn_pkg SHALL hold the FSM state typedef (btn_state_t) and the clog2-derived id-width constant function.
REQ-033 Sub-module wkt_btn_channel SHALL contain the synchronizer, FSM, debounce counter and optional long counter for one button, and SHALL be instantiated NBTN times.
REQ-034 Event-flag arbitration and the handshake SHALL reside in wkt_buttons.

Verification (NBTN=4, DEBOUNCE_CYCLES=16, LONG_CYCLES=64)
REQ-035 Hold i_btn[2] high from cycle 0 -> o_btn[2] rises at cycle 19 and o_evt_valid=1 with id=2 at cycle 20; ack -> o_evt_valid=0 next cycle.
REQ-036 Pulse i_btn[0] high for 10 cycles -> o_btn stays 0 and no event is raised.
REQ-037 Press buttons 3 and 1 in the same cycle -> id=1 is presented first; after ack, id=3 is presented the next cycle.
REQ-038 Press button 0 twice with no ack -> o_overrun=1 and exactly one id=0 event remains.
REQ-039 With WKT_BTN_LONGPRESS_EN, hold i_btn[1] for 120 cycles -> a press event and exactly one long event (o_evt_long=1, id=1).
REQ-040 Assert i_reset_n=0 at cycle 10 of a debounce -> all outputs 0; button still held -> o_btn rises 19 cycles after reset release.
